// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transaction path.
// States, length width and clock mode.
package spi_pkg;

  localparam int SPI_MAXLEN_DEF = 16;
  localparam int SPI_LEN_W = $clog2(SPI_MAXLEN_DEF) + 1;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period down-counter; one-cycle tick every H cycles while enabled.
// Reloads H-1 whenever disabled so each enable starts a full half-period.
module spi_sclk_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_half,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_en || r_cnt == '0) begin
      r_cnt <= i_half - W'(1);
    end else begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transaction controller: request handshake, CS/SCLK timing,
// MSB-first shift out, MISO capture and single-cycle response.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN = 16,
  parameter int CLK_DIV_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CLK_DIV_W-1:0]            clk_divide,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [$clog2(SPI_MAXLEN):0]     req_len,
  input  logic [SPI_MAXLEN-1:0]           req_data,
  output logic                            rsp_valid,
  output logic [SPI_MAXLEN-1:0]           rsp_data,
  output logic                            rsp_err,
  output logic                            busy,
  output logic                            spi_clk,
  output logic                            spi_cs_n,
  output logic                            spi_mosi,
  input  logic                            spi_miso
);

  localparam int LW = $clog2(SPI_MAXLEN) + 1;
  localparam logic [LW-1:0] MAXL = LW'(SPI_MAXLEN);

  spi_state_e r_state, w_next;

  logic [LW-1:0]         r_len, r_bitcnt;
  logic [CLK_DIV_W-1:0]  r_h, w_h_in, w_half;
  logic [SPI_MAXLEN-1:0] r_tx, r_rx, r_rsp_data, w_tx_al;
  logic                  r_rsp_err, r_sclk;
  logic                  w_accept, w_len_ok, w_tick, w_en, w_last;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_len_ok = (req_len != '0) && (req_len <= MAXL);
  assign w_h_in   = (clk_divide == '0) ? CLK_DIV_W'(1) : clk_divide;
  assign w_half   = (r_state == IDLE) ? w_h_in : r_h;
  assign w_tx_al  = req_data << (MAXL - req_len);
  assign w_en     = (r_state == SETUP) || (r_state == XFER)
                 || (r_state == HOLD);

  // Last event of XFER: end of the low half after the Nth fall.
  assign w_last = (r_state == XFER) && w_tick
               && (r_sclk == CPOL) && (r_bitcnt == r_len);

  spi_sclk_gen #(
    .W (CLK_DIV_W)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_half (w_half),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_len_ok ? SETUP : DONE;
      SETUP:   if (w_tick) w_next = XFER;
      XFER:    if (w_last) w_next = HOLD;
      HOLD:    if (w_tick) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    spi_cs_n  = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        spi_cs_n  = 1'b1;
      end
      DONE: begin
        spi_cs_n  = 1'b1;
        rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      r_bitcnt   <= '0;
      r_h        <= CLK_DIV_W'(1);
      r_tx       <= '0;
      r_rx       <= '0;
      r_sclk     <= CPOL;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_len    <= req_len;
      r_h      <= w_h_in;
      r_tx     <= w_len_ok ? w_tx_al : '0;
      r_rx     <= '0;
      r_bitcnt <= '0;
      r_sclk   <= CPOL;
      if (!w_len_ok) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end else if (w_tick) begin
      unique case (r_state)
        SETUP: begin
          r_sclk <= ~CPOL;
          r_rx   <= {r_rx[SPI_MAXLEN-2:0], spi_miso};
        end
        XFER: begin
          if (r_sclk != CPOL) begin
            r_sclk   <= CPOL;
            r_bitcnt <= r_bitcnt + LW'(1);
            if (r_bitcnt + LW'(1) != r_len) begin
              r_tx <= r_tx << 1;
            end
          end else if (!w_last) begin
            r_sclk <= ~CPOL;
            r_rx   <= {r_rx[SPI_MAXLEN-2:0], spi_miso};
          end
        end
        HOLD: begin
          r_tx       <= '0;
          r_rsp_data <= r_rx;
          r_rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign spi_clk  = r_sclk;
  assign spi_mosi = r_tx[SPI_MAXLEN-1];
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: timing, data, invalid length,
// reset abort and back-to-back requests.
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] clk_divide = 16'd1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_len = 5'd0;
  logic [15:0] req_data = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_clk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        loop_en = 1'b1;
  logic        miso_fix = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int acc_n, rsp_n, cs_low, rises, hi_run, hi_min, hi_max;
  int cs_hi_at = 0, cs_gap;
  int acc_t[4];
  int rsp_t[4];
  logic [15:0] rsp_dv[4];
  logic        rsp_ev[4];
  logic [15:0] mosi_seq;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  assign spi_miso = loop_en ? spi_mosi : miso_fix;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .SPI_MAXLEN (16),
    .CLK_DIV_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_divide (clk_divide),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_len    (req_len),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!spi_cs_n) cs_low++;
    if (spi_clk && !prev_sclk) begin
      rises++;
      mosi_seq = {mosi_seq[14:0], spi_mosi};
    end
    if (spi_clk) hi_run++;
    else if (hi_run > 0) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    prev_sclk = spi_clk;
    if (spi_cs_n && !prev_cs) cs_hi_at = cyc;
    if (!spi_cs_n && prev_cs) cs_gap = cyc - cs_hi_at;
    prev_cs = spi_cs_n;
    if (req_valid && req_ready) begin
      if (acc_n < 4) acc_t[acc_n] = cyc;
      acc_n++;
    end
    if (rsp_valid) begin
      if (rsp_n < 4) begin
        rsp_t[rsp_n]  = cyc;
        rsp_dv[rsp_n] = rsp_data;
        rsp_ev[rsp_n] = rsp_err;
      end
      rsp_n++;
    end
  end

  task automatic clr_mon();
    acc_n = 0; rsp_n = 0; cs_low = 0; rises = 0;
    hi_run = 0; hi_min = 1000; hi_max = 0; cs_gap = -1;
    mosi_seq = 16'h0;
    for (int i = 0; i < 4; i++) begin
      acc_t[i] = 0; rsp_t[i] = 0; rsp_dv[i] = 16'h0; rsp_ev[i] = 1'b0;
    end
  endtask

  task automatic start_req(input int len, input logic [15:0] data,
                           input logic [15:0] div);
    @(posedge clk); #1;
    req_len = 5'(len); req_data = data; clk_divide = div;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int bound);
    for (int i = 0; i < bound && rsp_n < n; i++) begin
      @(negedge clk); #1;
    end
    if (rsp_n < n) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses, want %0d", rsp_n, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", spi_mosi); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_loop_h1();
    loop_en = 1'b1;
    clr_mon();
    start_req(8, 16'h00A5, 16'd1);
    wait_rsp(1, 100);
    checks++; if (rsp_t[0] - acc_t[0] !== 19) begin errors++; $display("FAIL t1_rsp_lat: got %0d want 19", rsp_t[0] - acc_t[0]); end
    checks++; if (rsp_dv[0] !== 16'h00A5) begin errors++; $display("FAIL t1_data: got %h want 00a5", rsp_dv[0]); end
    checks++; if (rsp_ev[0] !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", rsp_ev[0]); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL t1_done_mosi: got %b want 0", spi_mosi); end
    @(negedge clk); #1;
    checks++; if (cs_low !== 18) begin errors++; $display("FAIL t1_cs_low: got %0d want 18", cs_low); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL t1_rises: got %0d want 8", rises); end
    checks++; if (mosi_seq[7:0] !== 8'hA5) begin errors++; $display("FAIL t1_mosi_seq: got %h want a5", mosi_seq[7:0]); end
    checks++; if (rsp_n !== 1) begin errors++; $display("FAIL t1_rsp_count: got %0d want 1", rsp_n); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t1_ready: got %b want 1", req_ready); end
    checks++; if (rsp_data !== 16'h00A5) begin errors++; $display("FAIL t1_hold: got %h want 00a5", rsp_data); end
  endtask

  task automatic test_div3_ones();
    loop_en = 1'b0; miso_fix = 1'b1;
    clr_mon();
    start_req(16, 16'h1234, 16'd3);
    wait_rsp(1, 300);
    @(negedge clk); #1;
    checks++; if (cs_low !== 102) begin errors++; $display("FAIL t2_cs_low: got %0d want 102", cs_low); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL t2_rises: got %0d want 16", rises); end
    checks++; if (hi_min !== 3 || hi_max !== 3) begin errors++; $display("FAIL t2_sclk_high: got min %0d max %0d want 3", hi_min, hi_max); end
    checks++; if (mosi_seq !== 16'h1234) begin errors++; $display("FAIL t2_mosi_seq: got %h want 1234", mosi_seq); end
    checks++; if (rsp_t[0] - acc_t[0] !== 103) begin errors++; $display("FAIL t2_rsp_lat: got %0d want 103", rsp_t[0] - acc_t[0]); end
    checks++; if (rsp_dv[0] !== 16'hFFFF) begin errors++; $display("FAIL t2_data: got %h want ffff", rsp_dv[0]); end
    loop_en = 1'b1;
  endtask

  task automatic test_div0();
    clr_mon();
    start_req(4, 16'h000C, 16'd0);
    wait_rsp(1, 100);
    @(negedge clk); #1;
    checks++; if (cs_low !== 10) begin errors++; $display("FAIL t3_cs_low: got %0d want 10", cs_low); end
    checks++; if (hi_max !== 1 || rises !== 4) begin errors++; $display("FAIL t3_sclk: got hi %0d rises %0d want 1 4", hi_max, rises); end
    checks++; if (rsp_t[0] - acc_t[0] !== 11) begin errors++; $display("FAIL t3_rsp_lat: got %0d want 11", rsp_t[0] - acc_t[0]); end
    checks++; if (rsp_dv[0] !== 16'h000C) begin errors++; $display("FAIL t3_data: got %h want 000c", rsp_dv[0]); end
  endtask

  task automatic test_bad_len();
    int lens[2];
    lens[0] = 0; lens[1] = 17;
    for (int k = 0; k < 2; k++) begin
      clr_mon();
      start_req(lens[k], 16'hFFFF, 16'd2);
      wait_rsp(1, 20);
      checks++; if (rsp_t[0] - acc_t[0] !== 1) begin errors++; $display("FAIL t4_rsp_lat len=%0d: got %0d want 1", lens[k], rsp_t[0] - acc_t[0]); end
      checks++; if (rsp_ev[0] !== 1'b1) begin errors++; $display("FAIL t4_err len=%0d: got %b want 1", lens[k], rsp_ev[0]); end
      checks++; if (rsp_dv[0] !== 16'h0) begin errors++; $display("FAIL t4_data len=%0d: got %h want 0000", lens[k], rsp_dv[0]); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_done len=%0d: got %b want 0", lens[k], req_ready); end
      @(negedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_t2 len=%0d: got %b want 1", lens[k], req_ready); end
      checks++; if (cs_low !== 0 || rises !== 0) begin errors++; $display("FAIL t4_pins len=%0d: got cs %0d rises %0d want 0 0", lens[k], cs_low, rises); end
    end
  endtask

  task automatic test_reset_abort();
    clr_mon();
    start_req(16, 16'hBEEF, 16'd2);
    repeat (10) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || spi_cs_n !== 1'b0) begin errors++; $display("FAIL t5_pre: got busy %b cs_n %b want 1 0", busy, spi_cs_n); end
    rst = 1'b0;
    #1;
    checks++; if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0) begin errors++; $display("FAIL t5_pins: got cs_n %b sclk %b want 1 0", spi_cs_n, spi_clk); end
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL t5_state: got busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (rsp_n !== 0) begin errors++; $display("FAIL t5_no_rsp: got %0d want 0", rsp_n); end
    clr_mon();
    start_req(8, 16'h005A, 16'd1);
    wait_rsp(1, 100);
    checks++; if (rsp_dv[0] !== 16'h005A) begin errors++; $display("FAIL t5_after: got %h want 005a", rsp_dv[0]); end
    checks++; if (rsp_t[0] - acc_t[0] !== 19) begin errors++; $display("FAIL t5_lat: got %0d want 19", rsp_t[0] - acc_t[0]); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    @(posedge clk); #1;
    req_len = 5'd2; req_data = 16'h0002; clk_divide = 16'd1;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clk_divide = 16'd7; req_data = 16'h0001;
    for (int i = 0; i < 50 && acc_n < 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(2, 100);
    @(negedge clk); #1;
    checks++; if (acc_n !== 2) begin errors++; $display("FAIL t6_accepts: got %0d want 2", acc_n); end
    checks++; if (acc_t[1] - acc_t[0] !== 8) begin errors++; $display("FAIL t6_accept_gap: got %0d want 8", acc_t[1] - acc_t[0]); end
    checks++; if (rsp_t[0] - acc_t[0] !== 7) begin errors++; $display("FAIL t6_lat1: got %0d want 7", rsp_t[0] - acc_t[0]); end
    checks++; if (rsp_t[1] - acc_t[1] !== 43) begin errors++; $display("FAIL t6_lat2: got %0d want 43", rsp_t[1] - acc_t[1]); end
    checks++; if (cs_gap !== 2) begin errors++; $display("FAIL t6_cs_gap: got %0d want 2", cs_gap); end
    checks++; if (cs_low !== 48) begin errors++; $display("FAIL t6_cs_low: got %0d want 48", cs_low); end
    checks++; if (rsp_dv[0] !== 16'h0002 || rsp_dv[1] !== 16'h0001) begin errors++; $display("FAIL t6_data: got %h %h want 0002 0001", rsp_dv[0], rsp_dv[1]); end
    checks++; if (rises !== 4) begin errors++; $display("FAIL t6_rises: got %0d want 4", rises); end
  endtask

  initial begin
    test_reset();
    test_loop_h1();
    test_div3_ones();
    test_div0();
    test_bad_len();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transaction controller for the SPI master. It accepts one word request through a valid/ready handshake and drives chip-select and a divided SPI clock. It shifts MOSI out MSB-first, samples MISO, and returns the received word as a single-cycle response. It sits between the register/command front end and the SPI pins, and it owns all SCLK generation and pulse counting.

Parameters:
SPI_MAXLEN, 16, maximum bits per transaction; also the data port width.
CLK_DIV_W, 16, width of the clk_divide input.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
clk_divide  input  CLK_DIV_W  SCLK half-period in clk cycles (H); 0 is treated as 1.
req_valid  input  1  transaction request.
req_ready  output  1  controller can accept a request (high only in IDLE).
req_len  input  $clog2(SPI_MAXLEN)+1  bit count N.
req_data  input  SPI_MAXLEN  TX word, right-aligned; bit N-1 is sent first.
rsp_valid  output  1  one-cycle pulse when the transaction completes; no backpressure.
rsp_data  output  SPI_MAXLEN  RX word, right-aligned; last sampled bit in bit 0; upper bits 0.
rsp_err  output  1  qualified by rsp_valid; 1 if N==0 or N>SPI_MAXLEN.
busy  output  1  high in any state other than IDLE.
spi_clk  output  1  SCLK, CPOL=0.
spi_cs_n  output  1  active-low chip select.
spi_mosi  output  1  serial data out.
spi_miso  input  1  serial data in; pre-synchronised externally.

Behaviour:
- Reset values (async, immediate): spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1. State=IDLE.
- Reset mid-transaction aborts it with no response; outputs take reset values at once.
- SPI mode 0: MOSI changes on SCLK falling edges (first bit at CS assertion). MISO is sampled in the clk cycle in which spi_clk is registered 0->1.
- Accept: req_valid && req_ready at cycle T. At T, capture req_len, req_data and H=max(clk_divide,1). Later input changes are ignored until the next accept.
- States:
  - IDLE: req_ready=1. On accept with valid N, go to SETUP. With invalid N, go to DONE with rsp_err=1.
  - SETUP: cs_n=0, mosi=data[N-1], spi_clk=0. Stay H cycles, then go to XFER.
  - XFER: 2N half-periods of H cycles each, alternating spi_clk 1/0, starting high. At each rising transition, shift in spi_miso. At each falling transition except the last, present the next bit. After the Nth falling transition, go to HOLD.
  - HOLD: cs_n=0, spi_clk=0. Stay H cycles, then go to DONE.
  - DONE: one cycle. cs_n=1, spi_clk=0, mosi=0, rsp_valid=1. Go to IDLE.
- Timing for a valid request with length N and half-period H:
  - spi_cs_n is low from T+1 to T+H*(2N+2) inclusive.
  - rsp_valid pulses at T+H*(2N+2)+1.
  - Exactly N rising edges on spi_clk.
- CS spacing: minimum CS-high gap between back-to-back transactions is 2 cycles (DONE plus the IDLE accept cycle).
- Invalid length (N==0 or N>SPI_MAXLEN): no CS, no SCLK. rsp_valid pulses at T+1 with rsp_err=1 and rsp_data=0.
- Half-period counter: CLK_DIV_W bits, counts H-1 down to 0. Tick on 0, then reload H-1.
- Bit counter: counts completed SCLK periods. Width is $clog2(SPI_MAXLEN)+1, and it never wraps because N≤SPI_MAXLEN.
- req_valid is ignored outside IDLE; the requester holds it until ready.
- rsp_data and rsp_err hold their values until the next rsp_valid.

Decomposition:
- Package spi_pkg:
  - typedef enum of the states {IDLE, SETUP, XFER, HOLD, DONE}.
  - localparam SPI_LEN_W = $clog2(SPI_MAXLEN)+1.
  - constants CPOL=0, CPHA=0.
- Sub-module spi_sclk_gen: half-period down-counter producing a one-cycle tick every H cycles while enabled, with reload on enable rise.
- Top level contains the FSM, shift registers and bit counter.

Test Plan:
1. H=1, N=8, req_data=0x00A5, miso looped to mosi -> cs_n low 18 cycles; 8 SCLK rising edges; mosi sequence 1,0,1,0,0,1,0,1; rsp_valid at T+19 with rsp_data=0x00A5, rsp_err=0.
2. clk_divide=3, N=16, req_data=0x1234, miso tied 1 -> cs_n low 102 cycles; SCLK high/low 3 cycles each; rsp_data=0xFFFF at T+103.
3. clk_divide=0, N=4, data=0xC -> timing identical to H=1: cs_n low 10 cycles; rsp at T+11; loopback rsp_data=0x000C.
4. req_len=0, then req_len=17 -> no cs_n/spi_clk activity; rsp_valid at T+1 with rsp_err=1 and rsp_data=0; req_ready back high at T+2.
5. rst low during XFER of a 16-bit H=2 transfer -> same cycle: cs_n=1, spi_clk=0, busy=0, no rsp_valid. After release, a new 8-bit H=1 loopback of 0x5A returns 0x005A.
6. req_valid held high with two queued requests, H=1, N=2 -> second accepted in the IDLE cycle after DONE; cs_n high exactly 2 cycles between transactions; clk_divide changed mid-transfer has no effect on the current transfer.
